// File: rtl/odd_parity_serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, externally supplied
// odd parity bit, then STOP_BITS stop bits. The word is accepted over a valid/ready handshake.
module odd_parity_serial_tx #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             parity_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             parity_q;
  logic             bit_end;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign in_ready = (state == IDLE);

  // bit_idx counts data bits in DATA and stop bits in STOP; shreg[0] always holds the next data bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_q   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (in_valid) begin
            shreg    <= data_in;
            parity_q <= parity_in;
            bit_idx  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              tx      <= parity_q;
              bit_idx <= '0;
              state   <= PARITY;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx    <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Bench for odd_parity_serial_tx: three instances (default, two stop bits, one clock per bit)
// checked cycle by cycle against a frame model fed from a scoreboard queue.
module tb_odd_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rstn [3];
  logic       vld  [3];
  logic       par  [3];
  logic [3:0] din  [3];
  logic       rdy  [3];
  logic       txo  [3];
  logic       bsy  [3];
  logic       fd   [3];

  always #5 clk = ~clk;

  odd_parity_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rstn[0]), .data_in(din[0]), .parity_in(par[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .frame_done(fd[0]));
  odd_parity_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rstn[1]), .data_in(din[1]), .parity_in(par[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .frame_done(fd[1]));
  odd_parity_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rstn[2]), .data_in(din[2]), .parity_in(par[2]), .in_valid(vld[2]),
    .in_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .frame_done(fd[2]));

  typedef struct {
    logic [3:0] d;
    logic       p;
  } word_t;

  typedef struct {
    int         k;
    logic [3:0] d;
    logic       p;
    logic [6:0] pat;   // first seven serial bits, first bit in the MSB
    int         lat;   // cycle (after the accepting edge) in which frame_done is high
  } vec_t;

  word_t      q0[$];
  word_t      q1[$];
  word_t      q2[$];
  int         checks;
  int         errors;
  int         cyc;
  bit         in_frame [3];
  bit         rst_prev [3];
  bit         pushed   [3];
  int         cnt      [3];
  int         done_cnt [3];
  word_t      cur      [3];
  logic [6:0] cap      [3];
  vec_t       tbl      [7];

  function automatic int cpb_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int sb_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic logic ebit(input word_t w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 4) return w.d[2'(idx - 1)];
    if (idx == 5) return w.p;
    return 1'b1;
  endfunction

  function automatic bit q_empty(input int k);
    case (k)
      0:       return q0.size() == 0;
      1:       return q1.size() == 0;
      default: return q2.size() == 0;
    endcase
  endfunction

  task automatic q_push(input int k, input word_t w);
    case (k)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic q_pop(input int k, output word_t w);
    case (k)
      0:       w = q0.pop_front();
      1:       w = q1.pop_front();
      default: w = q2.pop_front();
    endcase
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  // Compare one instance's outputs with the frame model for the cycle just ended.
  task automatic mon(input int k);
    int    total;
    int    b;
    word_t w;
    total = (6 + sb_of(k)) * cpb_of(k);
    if (rst_prev[k]) begin
      while (!q_empty(k)) q_pop(k, w);
      in_frame[k] = 1'b0;
      chk("reset_tx", k, 32'(txo[k]), 32'd1);
      chk("reset_busy", k, 32'(bsy[k]), 32'd0);
      chk("reset_done", k, 32'(fd[k]), 32'd0);
      chk("reset_ready", k, 32'(rdy[k]), 32'd1);
    end else begin
      if (!in_frame[k] && !q_empty(k)) begin
        q_pop(k, cur[k]);
        in_frame[k] = 1'b1;
        cnt[k]      = 0;
        cap[k]      = '0;
      end
      if (in_frame[k]) begin
        if (cnt[k] < total) begin
          b = cnt[k] / cpb_of(k);
          chk("tx_bit", k, 32'(txo[k]), 32'(ebit(cur[k], b)));
          if ((cnt[k] % cpb_of(k)) == 0 && b < 7) cap[k] = {cap[k][5:0], txo[k]};
          chk("busy_in_frame", k, 32'(bsy[k]), 32'd1);
          chk("done_in_frame", k, 32'(fd[k]), 32'd0);
          chk("ready_in_frame", k, 32'(rdy[k]), 32'd0);
          cnt[k]++;
        end else begin
          chk("done_pulse", k, 32'(fd[k]), 32'd1);
          chk("busy_at_done", k, 32'(bsy[k]), 32'd0);
          chk("tx_at_done", k, 32'(txo[k]), 32'd1);
          chk("ready_at_done", k, 32'(rdy[k]), 32'd1);
          in_frame[k] = 1'b0;
          done_cnt[k]++;
        end
      end else begin
        chk("idle_tx", k, 32'(txo[k]), 32'd1);
        chk("idle_busy", k, 32'(bsy[k]), 32'd0);
        chk("idle_done", k, 32'(fd[k]), 32'd0);
        chk("idle_ready", k, 32'(rdy[k]), 32'd1);
      end
    end
  endtask

  // Scoreboard push for transfers at the coming edge, then advance to the next negedge and check.
  task automatic cycle();
    word_t w;
    for (int k = 0; k < 3; k++) begin
      pushed[k]   = 1'b0;
      rst_prev[k] = !rstn[k];
      if (rstn[k] && vld[k] && !in_frame[k] && q_empty(k)) begin
        w.d = din[k];
        w.p = par[k];
        q_push(k, w);
        pushed[k] = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) mon(k);
  endtask

  task automatic wait_done(input int k, output int n);
    n = 1;
    while (fd[k] !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    if (fd[k] !== 1'b1) chk("timeout_frame_done", k, 32'(fd[k]), 32'd1);
  endtask

  task automatic send_frame(input int k, input logic [3:0] d, input logic p,
                            input logic [6:0] pat, input int lat);
    int n;
    din[k] = d;
    par[k] = p;
    vld[k] = 1'b1;
    cycle();
    vld[k] = 1'b0;
    wait_done(k, n);
    chk("frame_pattern", k, 32'(cap[k]), 32'(pat));
    chk("frame_latency", k, 32'(n), 32'(lat));
  endtask

  initial begin
    int n;
    int n1;
    int fds;
    int d0;

    tbl[0] = '{0, 4'b1011, 1'b0, 7'b0110101, 29};
    tbl[1] = '{0, 4'b0001, 1'b0, 7'b0100001, 29};
    tbl[2] = '{1, 4'b0110, 1'b1, 7'b0011011, 33};
    tbl[3] = '{1, 4'b0000, 1'b1, 7'b0000011, 33};
    tbl[4] = '{2, 4'b1000, 1'b0, 7'b0000101, 8};
    tbl[5] = '{0, 4'b1111, 1'b1, 7'b0111111, 29};
    tbl[6] = '{2, 4'b0101, 1'b1, 7'b0101011, 8};

    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int k = 0; k < 3; k++) begin
      rstn[k]     = 1'b0;
      vld[k]      = 1'b1;
      din[k]      = 4'b1111;
      par[k]      = 1'b1;
      in_frame[k] = 1'b0;
      cnt[k]      = 0;
      done_cnt[k] = 0;
      cap[k]      = '0;
    end

    // Reset held three cycles with in_valid asserted: nothing may start.
    for (int i = 0; i < 3; i++) cycle();
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b1;
      vld[k]  = 1'b0;
    end
    for (int i = 0; i < 4; i++) cycle();
    for (int k = 0; k < 3; k++) chk("no_frame_after_reset", k, 32'(done_cnt[k]), 32'd0);

    // Table of single frames across all three configurations.
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].k, tbl[i].d, tbl[i].p, tbl[i].pat, tbl[i].lat);
      cycle();
    end

    // Input changes and in_valid during a frame must not disturb it or start a transfer.
    din[0] = 4'b0001;
    par[0] = 1'b0;
    vld[0] = 1'b1;
    cycle();
    din[0] = 4'b1111;
    par[0] = 1'b1;
    wait_done(0, n);
    chk("stable_pattern", 0, 32'(cap[0]), 32'(7'b0100001));
    chk("stable_latency", 0, 32'(n), 32'd29);
    cycle();
    vld[0] = 1'b0;
    wait_done(0, n);
    chk("second_pattern", 0, 32'(cap[0]), 32'(7'b0111111));
    cycle();

    // Back-to-back frames with two stop bits and in_valid held.
    d0     = done_cnt[1];
    din[1] = 4'b0110;
    par[1] = 1'b1;
    vld[1] = 1'b1;
    cycle();
    din[1] = 4'b0000;
    n   = 1;
    n1  = 0;
    fds = 0;
    while (fds < 2 && n < 300) begin
      cycle();
      n++;
      if (pushed[1]) vld[1] = 1'b0;
      if (fd[1] === 1'b1) begin
        fds++;
        if (fds == 1) n1 = n;
      end
    end
    chk("b2b_done_pulses", 1, 32'(fds), 32'd2);
    chk("b2b_first_done", 1, 32'(n1), 32'd33);
    chk("b2b_second_done", 1, 32'(n), 32'd66);
    chk("b2b_model_frames", 1, 32'(done_cnt[1] - d0), 32'd2);
    chk("b2b_second_pattern", 1, 32'(cap[1]), 32'(7'b0000011));
    cycle();

    // Reset during data bit 2 abandons the frame without a done pulse.
    d0     = done_cnt[0];
    din[0] = 4'b1011;
    par[0] = 1'b0;
    vld[0] = 1'b1;
    cycle();
    vld[0] = 1'b0;
    for (int i = 2; i <= 14; i++) cycle();
    rstn[0] = 1'b0;
    cycle();
    rstn[0] = 1'b1;
    fds = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (fd[0] === 1'b1) fds++;
    end
    chk("no_done_after_abort", 0, 32'(fds), 32'd0);
    chk("abort_model_frames", 0, 32'(done_cnt[0] - d0), 32'd0);
    send_frame(0, 4'b0110, 1'b1, 7'b0011011, 29);
    for (int i = 0; i < 3; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
